fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares the single write port of the sample async FIFO among NUM_REQ capture sources (ADC channels, reference-counter snapshots) in the wr_clk domain. It tags each word with its source channel in the MSBs, holds a grant for bursts of up to MAX_BURST words, and stalls sources cleanly on FIFO full without losing or duplicating words.

---
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one async-FIFO write port among NUM_REQ sources.
//   wr_clk, rst (sync, active-high)
//   req_vld / req_data / req_ready : per-channel valid/ready sources, payload i at [i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
//   fifo_full                      : combinational full flag from the FIFO
//   fifo_data_in_vld / fifo_data_in: registered output slot, word = {channel tag, payload}
//   grant_id                       : currently / last granted channel
//   busy                           : burst in progress or output slot occupied
//   Optional FIFO_WR_ARB_STATS_EN adds stat_words (per-channel accepts) and stat_stall (full-stall cycles).
module fifo_wr_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int CH_W          = $clog2(NUM_REQ),
    parameter int PAYLOAD_WIDTH = 30,
    parameter int DATA_WIDTH    = PAYLOAD_WIDTH + CH_W,
    parameter int MAX_BURST     = 4
) (
    input  logic                             wr_clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_vld,
    input  logic [NUM_REQ*PAYLOAD_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             fifo_full,
    output logic                             fifo_data_in_vld,
    output logic [DATA_WIDTH-1:0]            fifo_data_in,
    output logic [CH_W-1:0]                  grant_id,
    output logic                             busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]            stat_words,
    output logic [31:0]                      stat_stall
`endif
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t                  state, state_nxt;
    logic [CH_W-1:0]         last_grant, last_grant_nxt, grant_nxt, winner, sel;
    logic [4:0]              burst_cnt, burst_cnt_nxt;
    logic                    out_vld, slot_free, accept, found;
    logic [DATA_WIDTH-1:0]   out_data;

    assign slot_free        = ~out_vld | ~fifo_full;
    assign fifo_data_in_vld = out_vld;
    assign fifo_data_in     = out_data;
    assign busy             = (state == HOLD) | out_vld;

    // First requesting channel after last_grant, wrapping modulo NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_vld[(int'(last_grant) + k) % NUM_REQ]) begin
                winner = CH_W'((int'(last_grant) + k) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    // A burst that reached MAX_BURST spends one HOLD cycle releasing, which is the
    // arbitration bubble between grants.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant_nxt      = grant_id;
        burst_cnt_nxt  = burst_cnt;
        req_ready      = '0;
        accept         = 1'b0;
        sel            = grant_id;
        if (state == IDLE) begin
            sel = winner;
            if (found && slot_free) begin
                req_ready[winner] = 1'b1;
                accept            = 1'b1;
                grant_nxt         = winner;
                burst_cnt_nxt     = 5'd1;
                state_nxt         = HOLD;
            end
        end else if (burst_cnt >= 5'(MAX_BURST)) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant_id;
        end else begin
            req_ready[grant_id] = slot_free;
            accept              = slot_free & req_vld[grant_id];
            if (accept)
                burst_cnt_nxt = burst_cnt + 5'd1;
            else if (slot_free) begin
                state_nxt      = IDLE;
                last_grant_nxt = grant_id;
            end
        end
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= CH_W'(NUM_REQ - 1);
            grant_id   <= '0;
            burst_cnt  <= '0;
            out_vld    <= 1'b0;
            out_data   <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            grant_id   <= grant_nxt;
            burst_cnt  <= burst_cnt_nxt;
            // Slot reloads in the same cycle it drains, or holds while the FIFO is full.
            if (accept) begin
                out_vld  <= 1'b1;
                out_data <= {sel, req_data[int'(sel)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]};
            end else if (!fifo_full)
                out_vld <= 1'b0;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            stat_words <= '0;
            stat_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_vld[i] && req_ready[i] && stat_words[i*32 +: 32] != 32'hFFFFFFFF)
                    stat_words[i*32 +: 32] <= stat_words[i*32 +: 32] + 32'd1;
            if (out_vld && fifo_full && stat_stall != 32'hFFFFFFFF)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector table plus randomized end-to-end scoreboard for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int PW = 30;
    localparam int DW = 32;
    localparam int NW = 100;

    logic            wr_clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_vld, req_ready;
    logic [N*PW-1:0] req_data;
    logic            fifo_full, fifo_data_in_vld, busy;
    logic [DW-1:0]   fifo_data_in;
    logic [1:0]      grant_id;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [N*32-1:0] stat_words;
    logic [31:0]     stat_stall;
`endif

    fifo_wr_arbiter dut (
        .wr_clk(wr_clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_data_in_vld(fifo_data_in_vld),
        .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy)
`ifdef FIFO_WR_ARB_STATS_EN
        , .stat_words(stat_words), .stat_stall(stat_stall)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    int vecs = 0, errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] fixp(input int i);
        return PW'(32'h0ABC_0000 + i);
    endfunction

    typedef struct {
        logic       r;
        logic [3:0] vld;
        logic       full;
        logic       chk;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] tag;
        logic [1:0] gid;
        logic       bsy;
    } vec_t;
    vec_t tbl[$];

    task automatic addv(input logic r, input logic [3:0] vld, input logic full, input logic c,
                        input logic [3:0] rdy, input logic ov, input logic [1:0] tag,
                        input logic [1:0] gid, input logic bsy, input int rep = 1);
        for (int k = 0; k < rep; k++) tbl.push_back('{r, vld, full, c, rdy, ov, tag, gid, bsy});
    endtask

    logic [PW-1:0] pay [N][NW];
    int            sidx[N], widx[N];
    logic [N-1:0]  acc;
    logic          prev_stall, done;
    logic [DW-1:0] prev_data;
    int            ch, cyc;

    initial begin
        rst = 1'b1; req_vld = '0; fifo_full = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*PW +: PW] = fixp(i);
        repeat (2) @(posedge wr_clk);
        #1 rst = 1'b0;
        @(negedge wr_clk);
        chk("rst_vld", 32'(fifo_data_in_vld), 0);
        chk("rst_data", fifo_data_in, 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge wr_clk); #1;

        // ch0 and ch2 bursts, then a 5-cycle full stall mid-burst
        addv(0, 4'b0101, 0, 1, 4'b0001, 0, 0, 0, 0);
        addv(0, 4'b0101, 0, 1, 4'b0001, 1, 0, 0, 1, 3);
        addv(0, 4'b0101, 0, 1, 4'b0000, 1, 0, 0, 1);
        addv(0, 4'b0101, 0, 1, 4'b0100, 0, 0, 0, 0);
        addv(0, 4'b0101, 0, 1, 4'b0100, 1, 2, 2, 1, 3);
        addv(0, 4'b0101, 0, 1, 4'b0000, 1, 2, 2, 1);
        addv(0, 4'b0101, 0, 1, 4'b0001, 0, 0, 2, 0);
        addv(0, 4'b0101, 1, 1, 4'b0000, 1, 0, 0, 1, 5);
        addv(0, 4'b0101, 0, 1, 4'b0001, 1, 0, 0, 1, 3);
        addv(0, 4'b0101, 0, 1, 4'b0000, 1, 0, 0, 1);
        addv(0, 4'b0101, 0, 1, 4'b0100, 0, 0, 0, 0);
        addv(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0);
        // ch1 sends two words then drops, ch2 next; then rst mid-burst
        addv(0, 4'b0110, 0, 1, 4'b0010, 0, 0, 0, 0);
        addv(0, 4'b0110, 0, 1, 4'b0010, 1, 1, 1, 1);
        addv(0, 4'b0100, 0, 1, 4'b0010, 1, 1, 1, 1);
        addv(0, 4'b0100, 0, 1, 4'b0100, 0, 0, 1, 0);
        addv(0, 4'b0100, 0, 1, 4'b0100, 1, 2, 2, 1);
        addv(1, 4'b0101, 1, 0, 4'b0000, 0, 0, 0, 0);
        addv(0, 4'b0101, 0, 1, 4'b0001, 0, 0, 0, 0);
        addv(0, 4'b0101, 0, 1, 4'b0001, 1, 0, 0, 1);

        for (int v = 0; v < tbl.size(); v++) begin
            rst = tbl[v].r; req_vld = tbl[v].vld; fifo_full = tbl[v].full;
            @(negedge wr_clk);
            if (tbl[v].chk) begin
                chk($sformatf("t%0d_ready", v), 32'(req_ready), 32'(tbl[v].rdy));
                chk($sformatf("t%0d_vld", v), 32'(fifo_data_in_vld), 32'(tbl[v].ov));
                chk($sformatf("t%0d_gid", v), 32'(grant_id), 32'(tbl[v].gid));
                chk($sformatf("t%0d_busy", v), 32'(busy), 32'(tbl[v].bsy));
                if (tbl[v].ov)
                    chk($sformatf("t%0d_data", v), fifo_data_in, {tbl[v].tag, fixp(int'(tbl[v].tag))});
            end
            @(posedge wr_clk); #1;
        end

        // Randomized traffic: every generated word must reach the FIFO once, in per-channel order
        rst = 1'b1; req_vld = '0; fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            sidx[i] = 0; widx[i] = 0;
            for (int j = 0; j < NW; j++) pay[i][j] = PW'($urandom);
        end
        acc = '0; prev_stall = 1'b0; prev_data = '0; done = 1'b0; cyc = 0;
        @(posedge wr_clk); #1 rst = 1'b0;
        while (!done && cyc < 20000) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin sidx[i]++; req_vld[i] = 1'b0; end
                if (!req_vld[i] && sidx[i] < NW && $urandom_range(0, 9) < 7) req_vld[i] = 1'b1;
                if (sidx[i] < NW) req_data[i*PW +: PW] = pay[i][sidx[i]];
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            @(negedge wr_clk);
            acc = req_vld & req_ready;
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
            if (prev_stall) begin
                chk("stall_hold_vld", 32'(fifo_data_in_vld), 1);
                chk("stall_hold_data", fifo_data_in, prev_data);
            end
            if (fifo_data_in_vld && fifo_full) chk("stall_ready", 32'(req_ready), 0);
            if (fifo_data_in_vld && !fifo_full) begin
                ch = int'(fifo_data_in[DW-1 -: 2]);
                if (widx[ch] >= NW) chk("extra_word", 32'(ch), 32'hFFFF_FFFF);
                else begin
                    chk($sformatf("word_ch%0d_%0d", ch, widx[ch]), fifo_data_in, {2'(ch), pay[ch][widx[ch]]});
                    widx[ch]++;
                end
            end
            prev_stall = fifo_data_in_vld & fifo_full;
            prev_data  = fifo_data_in;
            done = 1'b1;
            for (int i = 0; i < N; i++) if (widx[i] < NW) done = 1'b0;
            cyc++;
            @(posedge wr_clk); #1;
        end
        if (!done) chk("timeout", 32'(cyc), 0);
        for (int i = 0; i < N; i++) chk($sformatf("count_ch%0d", i), 32'(widx[i]), NW);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
